// File: rtl/phj_pkg.sv
// Shared types for the partitioned hash join datapath: tuple layout and
// splitter state encoding.
package phj_pkg;

   localparam int unsigned DATA_W   = 64;
   localparam int unsigned TAG_W    = 32;
   localparam int unsigned SERIAL_W = 64;
   localparam int unsigned TUPLE_W  = DATA_W + TAG_W + SERIAL_W + 1;

   typedef struct packed {
      logic [DATA_W-1:0]   data;
      logic [TAG_W-1:0]    tag;
      logic [SERIAL_W-1:0] serialnum;
      logic                was_joined;
   } tuple_t;

   typedef enum logic [1:0] {
      Init,
      Work,
      Drain,
      Done
   } SplitState;

endpackage

// File: rtl/tuple_fifo.sv
// Small register-based FIFO whose head entry drives the output directly, so a
// pushed entry is visible the cycle after the push with no bubble.
module tuple_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             head_valid,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full       = (count == (AW+1)'(DEPTH));
   assign empty      = (count == '0);
   assign do_pop     = pop & ~empty;
   // A pop frees the slot this cycle, so a push into a full FIFO is legal then.
   assign do_push    = push & (~full | do_pop);
   assign head_valid = ~empty;
   assign head       = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hash_split.sv
// Routes each input tuple to one of two output FIFOs by a single hash-tag bit and
// forwards end-of-stream to both branches once everything has drained.
module hash_split
   import phj_pkg::*;
#(
   parameter int unsigned INPUT_SIZE   = 64,
   parameter int unsigned DECISION_BIT = 0,
   parameter int unsigned DEPTH        = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       in_ready,
   input  logic [INPUT_SIZE-1:0]      in_data,
   input  logic [TAG_W-1:0]           in_tag,
   input  logic                       in_valid,
   input  logic [SERIAL_W-1:0]        in_serialnum,
   input  logic                       in_was_joined,
   input  logic                       in_last_processed,
   input  logic [1:0]                 ready_4_output,
   output logic [1:0][INPUT_SIZE-1:0] out_data,
   output logic [1:0][TAG_W-1:0]      out_tag,
   output logic [1:0]                 out_valid,
   output logic [1:0][SERIAL_W-1:0]   out_serialnum,
   output logic [1:0]                 out_was_joined,
   output logic [1:0]                 out_last_processed,
   output logic [1:0][31:0]           out_count
);

   localparam int unsigned FIFO_W = INPUT_SIZE + TAG_W + SERIAL_W + 1;

   SplitState              state;
   logic [1:0]             full;
   logic [1:0]             empty;
   logic [1:0]             push;
   logic [1:0]             pop;
   logic [1:0][FIFO_W-1:0] head;
   logic [FIFO_W-1:0]      in_tuple;
   logic                   accept;
   logic                   dest;

   // Readiness looks only at registered flags so it never depends on the tag.
   assign in_ready = (state == Work) & ~full[0] & ~full[1];
   assign accept   = in_valid & in_ready;
   assign dest     = in_tag[DECISION_BIT];
   assign in_tuple = {in_data, in_tag, in_serialnum, in_was_joined};

   for (genvar k = 0; k < 2; k++) begin : g_out
      assign push[k] = accept & (dest == 1'(k));
      assign pop[k]  = out_valid[k] & ready_4_output[k];
      assign {out_data[k], out_tag[k], out_serialnum[k], out_was_joined[k]} = head[k];

      tuple_fifo #(
         .WIDTH (FIFO_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk        (clk),
         .reset      (reset),
         .push       (push[k]),
         .push_data  (in_tuple),
         .pop        (pop[k]),
         .full       (full[k]),
         .empty      (empty[k]),
         .head_valid (out_valid[k]),
         .head       (head[k])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_count <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (pop[k]) begin
               out_count[k] <= out_count[k] + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= Init;
         out_last_processed <= 2'b00;
      end else begin
         unique case (state)
            Init: state <= Work;
            Work: begin
               if (in_last_processed && !in_valid) begin
                  state <= Drain;
               end
            end
            Drain: begin
               if (&empty) begin
                  state              <= Done;
                  out_last_processed <= 2'b11;
               end
            end
            Done: state <= Done;
            default: state <= Init;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_split.sv
// Directed and randomized bench for hash_split; per-output queues model the
// routing rule and the expected delivery order.
module tb_hash_split;
   import phj_pkg::*;

   localparam int unsigned DB = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_ready;
   logic [63:0]       in_data;
   logic [31:0]       in_tag;
   logic              in_valid;
   logic [63:0]       in_serialnum;
   logic              in_was_joined;
   logic              in_last_processed;
   logic [1:0]        ready_4_output;
   logic [1:0][63:0]  out_data;
   logic [1:0][31:0]  out_tag;
   logic [1:0]        out_valid;
   logic [1:0][63:0]  out_serialnum;
   logic [1:0]        out_was_joined;
   logic [1:0]        out_last_processed;
   logic [1:0][31:0]  out_count;

   int          compared   = 0;
   int          mismatched = 0;
   tuple_t      q [2][$];
   logic [31:0] exp_cnt [2];
   logic [63:0] last_ser [2];
   logic [63:0] ser_n = 64'd0;
   tuple_t      e;
   tuple_t      t;

   always #5 clk = ~clk;

   hash_split #(
      .INPUT_SIZE   (64),
      .DECISION_BIT (DB),
      .DEPTH        (2)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .in_ready           (in_ready),
      .in_data            (in_data),
      .in_tag             (in_tag),
      .in_valid           (in_valid),
      .in_serialnum       (in_serialnum),
      .in_was_joined      (in_was_joined),
      .in_last_processed  (in_last_processed),
      .ready_4_output     (ready_4_output),
      .out_data           (out_data),
      .out_tag            (out_tag),
      .out_valid          (out_valid),
      .out_serialnum      (out_serialnum),
      .out_was_joined     (out_was_joined),
      .out_last_processed (out_last_processed),
      .out_count          (out_count)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Reference model: sampled mid-cycle, owns all expected-value state.
   always @(negedge clk) begin
      if (reset) begin
         q[0].delete();
         q[1].delete();
         exp_cnt[0]  = 32'd0;
         exp_cnt[1]  = 32'd0;
         last_ser[0] = 64'd0;
         last_ser[1] = 64'd0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            check("olp_excl", 64'(out_last_processed[k] & out_valid[k]), 64'd0);
            if (out_valid[k] && ready_4_output[k]) begin
               check("out_expected", 64'(q[k].size() > 0), 64'd1);
               if (q[k].size() > 0) begin
                  e = q[k].pop_front();
                  check("out_data", out_data[k], e.data);
                  check("out_tag", 64'(out_tag[k]), 64'(e.tag));
                  check("out_serial", out_serialnum[k], e.serialnum);
                  check("out_joined", 64'(out_was_joined[k]), 64'(e.was_joined));
                  check("serial_mono", 64'(out_serialnum[k] > last_ser[k]), 64'd1);
                  last_ser[k] = out_serialnum[k];
                  exp_cnt[k]  = exp_cnt[k] + 32'd1;
               end
            end
         end
         if (in_valid && in_ready) begin
            t.data       = in_data;
            t.tag        = in_tag;
            t.serialnum  = in_serialnum;
            t.was_joined = in_was_joined;
            q[in_tag[DB]].push_back(t);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] tag);
      ser_n         = ser_n + 64'd1;
      in_valid      = 1'b1;
      in_data       = {$urandom, $urandom};
      in_tag        = tag;
      in_serialnum  = ser_n;
      in_was_joined = 1'($urandom);
   endtask

   task automatic wait_accept(output int cycles);
      logic acc;
      acc    = 1'b0;
      cycles = 0;
      for (int i = 0; i < 200 && !acc; i++) begin
         acc = in_ready;
         tick();
         cycles++;
      end
      check("send_accept", 64'(acc), 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] tag);
      int c;
      drive(tag);
      wait_accept(c);
   endtask

   task automatic check_counts(input string name);
      check({name, "_cnt0"}, 64'(out_count[0]), 64'(exp_cnt[0]));
      check({name, "_cnt1"}, 64'(out_count[1]), 64'(exp_cnt[1]));
      check({name, "_q0"}, 64'(q[0].size()), 64'd0);
      check({name, "_q1"}, 64'(q[1].size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired compared=%0d", compared);
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int total;
      int sent;
      logic acc;

      reset             = 1'b1;
      in_valid          = 1'b0;
      in_data           = '0;
      in_tag            = '0;
      in_serialnum      = '0;
      in_was_joined     = 1'b0;
      in_last_processed = 1'b0;
      ready_4_output    = 2'b11;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_data0", out_data[0], 64'd0);
      check("rst_data1", out_data[1], 64'd0);
      check("rst_tag", 64'(out_tag), 64'd0);
      check("rst_serial1", out_serialnum[1], 64'd0);
      check("rst_joined", 64'(out_was_joined), 64'd0);
      check("rst_olp", 64'(out_last_processed), 64'd0);
      check("rst_count", 64'(out_count), 64'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      check("init_ready", 64'(in_ready), 64'd0);
      tick();
      check("work_ready", 64'(in_ready), 64'd1);

      // Routing on bit 3.
      send(32'h08);
      send(32'h00);
      send(32'h0F);
      send(32'h10);
      repeat (4) tick();
      check("route_cnt0", 64'(out_count[0]), 64'd2);
      check("route_cnt1", 64'(out_count[1]), 64'd2);
      check_counts("route");

      // Back-pressure and cross-coupling with output 0 stalled.
      ready_4_output = 2'b10;
      drive(32'h00);
      check("bp_ready1", 64'(in_ready), 64'd1);
      tick();
      drive(32'h20);
      check("bp_ready2", 64'(in_ready), 64'd1);
      tick();
      check("bp_full", 64'(in_ready), 64'd0);
      drive(32'h08);
      repeat (3) begin
         tick();
         check("cross_ready", 64'(in_ready), 64'd0);
         check("cross_idle1", 64'(out_valid[1]), 64'd0);
      end
      drive(32'h40);
      tick();
      check("bp_hold", 64'(in_ready), 64'd0);
      check("bp_hold_cnt", 64'(out_count[0]), 64'd2);
      ready_4_output = 2'b11;
      wait_accept(cyc);
      repeat (4) tick();
      check("bp_cnt0_total", 64'(out_count[0]), 64'd5);
      check_counts("bp");

      // End of stream with output 1 stalled for 10 cycles.
      ready_4_output = 2'b01;
      send(32'h00);
      send(32'h20);
      send(32'h40);
      send(32'h08);
      send(32'h18);
      in_last_processed = 1'b1;
      tick();
      check("drain_ready", 64'(in_ready), 64'd0);
      check("drain_olp", 64'(out_last_processed), 64'd0);
      repeat (9) begin
         tick();
         check("stall_olp", 64'(out_last_processed), 64'd0);
      end
      ready_4_output = 2'b11;
      tick();
      check("pop1_olp", 64'(out_last_processed), 64'd0);
      tick();
      check("pop2_olp", 64'(out_last_processed), 64'd0);
      check("pop2_valid", 64'(out_valid), 64'd0);
      tick();
      check("done_olp", 64'(out_last_processed), 64'd3);
      drive(32'h00);
      repeat (3) begin
         tick();
         check("done_hold_olp", 64'(out_last_processed), 64'd3);
         check("done_ready", 64'(in_ready), 64'd0);
         check("done_valid", 64'(out_valid), 64'd0);
      end
      in_valid = 1'b0;
      check("eos_cnt0", 64'(out_count[0]), 64'd8);
      check("eos_cnt1", 64'(out_count[1]), 64'd4);
      check_counts("eos");

      // Reset from Done, then 100 random tuples at full rate.
      reset = 1'b1;
      in_last_processed = 1'b0;
      #1;
      check("rst2_count", 64'(out_count), 64'd0);
      check("rst2_olp", 64'(out_last_processed), 64'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      tick();
      total = 0;
      for (int i = 0; i < 100; i++) begin
         drive($urandom);
         wait_accept(cyc);
         total += cyc;
      end
      repeat (3) tick();
      check("thru_cycles", 64'(total), 64'd100);
      check("thru_sum", 64'(out_count[0] + out_count[1]), 64'd100);
      check_counts("thru");

      // Random consumer readiness.
      sent = 0;
      for (int i = 0; i < 3000 && sent < 200; i++) begin
         if (!in_valid) drive($urandom);
         ready_4_output = 2'($urandom);
         acc = in_valid & in_ready;
         tick();
         if (acc) begin
            sent++;
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      ready_4_output = 2'b11;
      repeat (5) tick();
      check("rand_sent", 64'(sent), 64'd200);
      check_counts("rand");

      // Reset with two tuples buffered.
      ready_4_output = 2'b00;
      send(32'h00);
      send(32'h08);
      check("pre_rst_valid", 64'(out_valid), 64'd3);
      #3 reset = 1'b1;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_count", 64'(out_count), 64'd0);
      check("mid_rst_data", out_data[0], 64'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      check("mid_init_ready", 64'(in_ready), 64'd0);
      tick();
      check("mid_work_ready", 64'(in_ready), 64'd1);
      check("mid_valid_after", 64'(out_valid), 64'd0);
      ready_4_output = 2'b11;
      send(32'h08);
      send(32'h00);
      repeat (3) tick();
      check("post_rst_cnt0", 64'(out_count[0]), 64'd1);
      check_counts("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hash_split.md
# hash_split

Single-input, dual-output router for the partitioned hash join: the fan-out counterpart of the two-input merging gate. Each valid tuple goes to output 0 or output 1 according to bit `DECISION_BIT` of its hash tag. Each output has its own small FIFO so a stalled consumer back-pressures the input only once that FIFO fills. It sits in front of a pair of gates in the partitioning tree and forwards end-of-stream (`last_processed`) to both branches once fully drained.

## Interface
- `INPUT_SIZE`, 64: tuple payload width.
- `DECISION_BIT`, 0: tag bit index used for routing, 0..31.
- `DEPTH`, 2: entries per output FIFO, power of two, ≥ 2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_ready` out 1: input handshake ready.
- `in_data` in `INPUT_SIZE`: tuple payload.
- `in_tag` in 32: hash digest.
- `in_valid` in 1: input tuple valid.
- `in_serialnum` in 64: tuple serial number.
- `in_was_joined` in 1: joined flag, passed through.
- `in_last_processed` in 1: upstream has no more tuples.
- `ready_4_output` in [1:0]: per-output consumer ready.
- `out_data` out [1:0][`INPUT_SIZE`]: per-output payload.
- `out_tag` out [1:0][32]: per-output tag.
- `out_valid` out [1:0]: per-output valid.
- `out_serialnum` out [1:0][64]: per-output serial number.
- `out_was_joined` out [1:0]: per-output joined flag.
- `out_last_processed` out [1:0]: per-output end-of-stream.
- `out_count` out [1:0][32]: tuples delivered per output (counted on output handshake).

## Operation
- Input handshake: `in_valid & in_ready`. Output handshake k: `out_valid[k] & ready_4_output[k]`.
- Routing: destination k = `in_tag[DECISION_BIT]`. The tuple (data, tag, serialnum, was_joined) is pushed into FIFO k.
- `in_ready` = (State == Work) & both FIFOs not full. It does not depend on `in_tag` or `in_valid`.
- FIFO k head drives output k. Pop on output handshake k. Push and pop in the same cycle are both legal, including when the FIFO is full with a pop pending. `in_ready` stays conservative: it is based on the registered full flag only.
- State machine, enum `SplitState`:
  - Init → Work after one cycle.
  - Work → Drain when `in_last_processed & ~in_valid`. A tuple accepted in the same cycle is impossible (`in_valid` is low).
  - Drain → Done when both FIFOs are empty. `in_ready` is 0 in Drain.
  - Done: `out_last_processed = 2'b11`, held until reset. `in_ready` = 0. Further `in_valid` is ignored.
- `out_last_processed[k]` is asserted only in Done, never while `out_valid[k]` is high.
- `out_count[k]` increments on each output handshake k and wraps modulo 2^32.
- Reset mid-operation: FIFOs are flushed and in-flight tuples are discarded; no partial output remains.

## Timing
- Reset values:
  - State = Init.
  - `in_ready` = 0.
  - `out_valid` = 0.
  - `out_data`, `out_tag`, `out_serialnum` = 0.
  - `out_was_joined` = 0, `out_last_processed` = 0.
  - `out_count` = 0.
  - FIFO pointers and occupancy = 0.
- First cycle after reset deassert: Init, `in_ready` = 0. Second cycle: Work, `in_ready` = 1.
- Latency: a tuple accepted at edge N appears on `out_valid[k]` after edge N (registered FIFO head), with no bubble.
- Throughput: 1 tuple/cycle sustained when both consumers hold ready high, for any tag pattern.
- A full FIFO on either side deasserts `in_ready` on the cycle after the push that filled it, even when the next tuple targets the other output. This coupling is intentional and keeps `in_ready` data-independent.
- Done is reached at the earliest one cycle after the last output handshake empties the final FIFO.
- `out_*` payload is stable while `out_valid[k]` is high and `ready_4_output[k]` is low.

## Structure
- Package `phj_pkg`: `typedef struct packed` `tuple_t` {data, tag, serialnum, was_joined}. It is parameterized via a localparam `TUPLE_W` or via per-field width localparams. `SplitState` enum {Init, Work, Drain, Done}.
- Sub-module `tuple_fifo`: parameters `WIDTH` and `DEPTH`, same clk/reset. Ports: push/pop, full/empty, and a registered head output with valid. Instantiated twice, once per output.
- Top level holds the FSM, routing demux, `in_ready` logic and the counters.

## Test plan
- Routing, `DECISION_BIT`=3, both outputs ready. Input tags 0x08, 0x00, 0x0F, 0x10, serialnums 1..4. Expected: output 1 gets serials 1, 3; output 0 gets 2, 4, in order; `out_count` = {2, 2}.
- Back-pressure, `DEPTH`=2. `ready_4_output[0]` = 0; push 3 tuples with tag bit = 0. Expected: `in_ready` drops after the second push; the third is accepted only after `ready_4_output[0]` rises; no tuple is lost or duplicated.
- Cross-coupling: output 0 full and stalled; offer a tuple with tag bit = 1. Expected: `in_ready` = 0 and output 1 idle until output 0 pops.
- End of stream: 5 tuples, then `in_last_processed` = 1 with `in_valid` = 0, and output 1 stalled for 10 cycles. Expected: state Drain; `out_last_processed` stays 0 until the last output 1 handshake, then reads 2'b11 the next cycle and holds.
- Simultaneous push and pop on a full FIFO with continuous ready: 100 random-tag tuples. Expected: `out_count[0] + out_count[1]` = 100, and per-output serial order is monotonic.
- Reset mid-stream: assert `reset` with 2 tuples buffered. Expected: `out_valid` = 0 and `out_count` = 0 immediately (asynchronous); `in_ready` returns to 1 on the second cycle after release.
